cali_err_align: RTL and testbench
=================================

CALI_ERR_ALIGN -- requirements
Module: cali_err_align

Interface
REQ-001 Parameter X_W, default 12, DTC code fraction width (unsigned, X = code/2^X_W in [0,1)).
REQ-002 Parameter TDC_W, default 10, signed TDC phase-error input width.
REQ-003 Parameter ERR_W, default 16, signed aligned-error output width.
REQ-004 Parameter DMAX, default 15, maximum loop latency in cycles (delay line depth DMAX+1).
REQ-005 Parameter OTHR, default 384, outlier threshold on |TDC_IN| in TDC LSBs.
REQ-006 CLK  input  1  calibration clock (one tick per reference cycle).
REQ-007 NRST  input  1  reset; one clock, asynchronous, active-low.
REQ-008 EN  input  1  calibration enable.
REQ-009 DLY  input  4  loop latency between DTC code application and the matching TDC result.
REQ-010 GSHIFT  input  3  error gain, left shift 0..7.
REQ-011 X_IN  input  X_W  DTC fractional code applied this cycle.
REQ-012 TDC_IN  input  TDC_W  signed TDC phase error, two's complement.
REQ-013 TDC_VLD  input  1  TDC_IN valid this cycle.
REQ-014 X_OUT  output  X_W  code aligned to ERR_OUT, feeds the piecewise RLS X input.
REQ-015 ERR_OUT  output  ERR_W  scaled, saturated error, feeds the RLS ERR input.
REQ-016 EN_OUT  output  1  update strobe, feeds the RLS EN input.
REQ-017 OUTLIER_CNT  output  8  saturating count of rejected samples.

Function
REQ-018 A delay line of DMAX+1 X_W-bit entries shifts X_IN in every cycle, independent of TDC_VLD and state.
REQ-019 Effective latency DL = max(DLY,1), capped at DMAX; DLY=0 behaves as DLY=1.
REQ-020 Outputs are registered: on each edge X_OUT <= X_IN sampled DL cycles earlier, ERR_OUT <= sat(TDC_IN << GSHIFT) to ERR_W bits; 1-cycle input-to-output latency.
REQ-021 Saturation clips to +(2^(ERR_W-1)-1) / -(2^(ERR_W-1)); the shift is sign-preserving.
REQ-022 FSM states: IDLE, FILL, RUN.
REQ-023 IDLE -> FILL when EN=1; any state -> IDLE when EN=0 (same edge).
REQ-024 FILL loads a counter with DL and decrements each cycle; FILL -> RUN when the counter reaches 0, so no stale delay-line entry is ever used.
REQ-025 RUN -> FILL (counter reloaded) on any cycle where DLY differs from its value registered in the previous cycle.
REQ-026 Outlier: |TDC_IN| > OTHR with TDC_VLD=1; -2^(TDC_W-1) is always an outlier.
REQ-027 EN_OUT <= 1 only when state is RUN, TDC_VLD=1 and the sample is not an outlier; otherwise EN_OUT <= 0 and ERR_OUT <= 0.
REQ-028 OUTLIER_CNT increments on each outlier in RUN, saturates at 255, and clears on the IDLE -> FILL transition.
REQ-029 X_OUT updates every cycle regardless of EN_OUT, so the RLS model output Y tracks the current code.

Reset
REQ-030 NRST low asynchronously forces state IDLE, fill counter 0, all delay-line entries 0, X_OUT=0, ERR_OUT=0, EN_OUT=0, OUTLIER_CNT=0, registered DLY=0.
REQ-031 After NRST deasserts, the first transition is IDLE -> FILL at the first edge with EN=1; a reset in RUN requires a full FILL again.

Structure
REQ-032 Shared package cali_pkg holds the FSM state enum, the default widths X_W/TDC_W/ERR_W and the saturation-width helper constants.
REQ-033 One sub-module, cali_dly_line (parameterised width/depth shift register with variable tap select), implements REQ-018/020 X path; the FSM, scaling and outlier logic stay in cali_err_align.

Verification
REQ-034 Reset then EN=1, DLY=3, X_IN ramps 0,1,2,... each cycle, TDC_VLD=1, TDC_IN=5 -> EN_OUT=0 during the 3 FILL cycles; thereafter X_OUT=X_IN(t-3) every cycle, ERR_OUT=5, EN_OUT=1.
REQ-035 RUN, GSHIFT=7, TDC_IN=+300 then -300 -> ERR_OUT=+32767 then -32768 (saturated, EN_OUT=1 since 300<=384).
REQ-036 RUN, TDC_IN=400 for 3 cycles then 10 -> EN_OUT=0 and ERR_OUT=0 for 3 cycles, OUTLIER_CNT=3, then EN_OUT=1, ERR_OUT=10 (GSHIFT=0).
REQ-037 RUN, DLY changed 3 -> 6 -> EN_OUT=0 for exactly 6 cycles, then X_OUT=X_IN(t-6); DLY=0 -> behaves as latency 1.
REQ-038 EN dropped mid-RUN for 1 cycle, then NRST pulsed mid-FILL -> IDLE immediately, all outputs 0 asynchronously, OUTLIER_CNT=0, full FILL on re-enable.

Source files
------------

// File: rtl/cali_pkg.sv
`default_nettype none
// Shared types and default widths for the calibration error-alignment path.
package cali_pkg;

  localparam int CALI_X_W        = 12;
  localparam int CALI_TDC_W      = 10;
  localparam int CALI_ERR_W      = 16;
  localparam int CALI_DLY_W      = 4;
  localparam int CALI_GSHIFT_W   = 3;
  localparam int CALI_GSHIFT_MAX = (1 << CALI_GSHIFT_W) - 1;
  localparam int CALI_OCNT_W     = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_RUN  = 2'd2
  } cali_state_e;

  // Width that holds TDC_IN at the largest gain shift and both saturation limits.
  function automatic int cali_sat_w(input int tdc_w, input int err_w);
    int prod_w;
    prod_w = tdc_w + CALI_GSHIFT_MAX;
    return (prod_w > err_w) ? prod_w : err_w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cali_dly_line.sv
`default_nettype none
// Free-running code delay line with a selectable tap and registered output.
// Tap 0 is the live input, tap k is the input sampled k edges earlier.
module cali_dly_line #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 16,
  parameter int SEL_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] din_i,
  input  logic [SEL_W-1:0] sel_i,
  output logic [WIDTH-1:0] dout_o
);

  logic [WIDTH-1:0] line_q [DEPTH-1];
  logic [WIDTH-1:0] taps   [DEPTH];
  logic [WIDTH-1:0] dout_q;

  assign taps[0] = din_i;
  for (genvar k = 1; k < DEPTH; k++) begin : g_tap
    assign taps[k] = line_q[k-1];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < DEPTH-1; k++) begin
        line_q[k] <= '0;
      end
      dout_q <= '0;
    end else begin
      line_q[0] <= din_i;
      for (int k = 1; k < DEPTH-1; k++) begin
        line_q[k] <= line_q[k-1];
      end
      dout_q <= taps[sel_i];
    end
  end

  assign dout_o = dout_q;

endmodule
`default_nettype wire

// File: rtl/cali_err_align.sv
`default_nettype none
// Aligns the DTC code with its delayed TDC phase error, scales/saturates the
// error, rejects outliers and strobes the downstream RLS update.
module cali_err_align
  import cali_pkg::*;
#(
  parameter int X_W   = CALI_X_W,
  parameter int TDC_W = CALI_TDC_W,
  parameter int ERR_W = CALI_ERR_W,
  parameter int DMAX  = 15,
  parameter int OTHR  = 384
) (
  input  logic                     clk_i,
  input  logic                     nrst_i,
  input  logic                     en_i,
  input  logic [CALI_DLY_W-1:0]    dly_i,
  input  logic [CALI_GSHIFT_W-1:0] gshift_i,
  input  logic [X_W-1:0]           x_in_i,
  input  logic [TDC_W-1:0]         tdc_in_i,
  input  logic                     tdc_vld_i,
  output logic [X_W-1:0]           x_out_o,
  output logic [ERR_W-1:0]         err_out_o,
  output logic                     en_out_o,
  output logic [CALI_OCNT_W-1:0]   outlier_cnt_o
);

  localparam int WIDE_W = cali_sat_w(TDC_W, ERR_W);
  localparam logic [CALI_DLY_W-1:0]   C_DMAX    = CALI_DLY_W'(DMAX);
  localparam logic [TDC_W:0]          C_OTHR    = (TDC_W+1)'(OTHR);
  localparam logic signed [WIDE_W-1:0] C_ERR_MAX =
    {{(WIDE_W-ERR_W+1){1'b0}}, {(ERR_W-1){1'b1}}};
  localparam logic signed [WIDE_W-1:0] C_ERR_MIN =
    {{(WIDE_W-ERR_W+1){1'b1}}, {(ERR_W-1){1'b0}}};

  cali_state_e              state_q;
  logic [CALI_DLY_W-1:0]    cnt_q;
  logic [CALI_DLY_W-1:0]    dly_q;
  logic [ERR_W-1:0]         err_q;
  logic                     en_out_q;
  logic [CALI_OCNT_W-1:0]   ocnt_q;

  logic [CALI_DLY_W-1:0]    dl;
  logic signed [WIDE_W-1:0] tdc_wide;
  logic signed [WIDE_W-1:0] tdc_shl;
  logic [ERR_W-1:0]         err_sat;
  logic [TDC_W:0]           tdc_abs;
  logic                     tdc_is_min;
  logic                     is_outlier;
  logic                     in_run;
  logic                     en_out_d;
  logic [ERR_W-1:0]         err_d;

  // DLY=0 is treated as a latency of one cycle.
  always_comb begin
    dl = dly_i;
    if (dly_i == '0) begin
      dl = CALI_DLY_W'(1);
    end else if (dly_i > C_DMAX) begin
      dl = C_DMAX;
    end
  end

  cali_dly_line #(
    .WIDTH(X_W),
    .DEPTH(DMAX + 1),
    .SEL_W(CALI_DLY_W)
  ) u_dly_line (
    .clk_i  (clk_i),
    .rst_ni (nrst_i),
    .din_i  (x_in_i),
    .sel_i  (dl),
    .dout_o (x_out_o)
  );

  assign tdc_wide = {{(WIDE_W-TDC_W){tdc_in_i[TDC_W-1]}}, tdc_in_i};
  assign tdc_shl  = tdc_wide <<< gshift_i;

  always_comb begin
    err_sat = tdc_shl[ERR_W-1:0];
    if (tdc_shl > C_ERR_MAX) begin
      err_sat = C_ERR_MAX[ERR_W-1:0];
    end else if (tdc_shl < C_ERR_MIN) begin
      err_sat = C_ERR_MIN[ERR_W-1:0];
    end
  end

  // Magnitude is one bit wider so the most negative code has a true absolute value.
  assign tdc_abs    = tdc_in_i[TDC_W-1] ? ((TDC_W+1)'(0) - {1'b1, tdc_in_i})
                                        : {1'b0, tdc_in_i};
  assign tdc_is_min = (tdc_in_i == {1'b1, {(TDC_W-1){1'b0}}});
  assign is_outlier = tdc_vld_i & (tdc_is_min | (tdc_abs > C_OTHR));

  assign in_run   = (state_q == ST_RUN) & en_i;
  assign en_out_d = in_run & tdc_vld_i & ~is_outlier;
  assign err_d    = en_out_d ? err_sat : '0;

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      dly_q    <= '0;
      err_q    <= '0;
      en_out_q <= 1'b0;
      ocnt_q   <= '0;
    end else begin
      dly_q    <= dly_i;
      en_out_q <= en_out_d;
      err_q    <= err_d;
      if (in_run && is_outlier && (ocnt_q != {CALI_OCNT_W{1'b1}})) begin
        ocnt_q <= ocnt_q + CALI_OCNT_W'(1);
      end
      if (!en_i) begin
        state_q <= ST_IDLE;
      end else begin
        case (state_q)
          ST_IDLE: begin
            state_q <= ST_FILL;
            cnt_q   <= dl;
            ocnt_q  <= '0;
          end
          ST_FILL: begin
            cnt_q <= (cnt_q == '0) ? '0 : cnt_q - CALI_DLY_W'(1);
            if (cnt_q <= CALI_DLY_W'(1)) begin
              state_q <= ST_RUN;
            end
          end
          ST_RUN: begin
            // A latency change re-primes the alignment before updates resume.
            if (dly_i != dly_q) begin
              state_q <= ST_FILL;
              cnt_q   <= dl;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign err_out_o     = err_q;
  assign en_out_o      = en_out_q;
  assign outlier_cnt_o = ocnt_q;

endmodule
`default_nettype wire

// File: tb/tb_cali_err_align.sv
`default_nettype none
// Randomised and directed bench for cali_err_align against a timestamp-based reference model.
module tb_cali_err_align;

  localparam int X_W   = 12;
  localparam int TDC_W = 10;
  localparam int ERR_W = 16;
  localparam int DMAX  = 15;
  localparam int OTHR  = 384;

  logic             clk = 1'b0;
  logic             nrst;
  logic             en;
  logic [3:0]       dly;
  logic [2:0]       gshift;
  logic [X_W-1:0]   x_in;
  logic [TDC_W-1:0] tdc_in;
  logic             tdc_vld;
  logic [X_W-1:0]   x_out;
  logic [ERR_W-1:0] err_out;
  logic             en_out;
  logic [7:0]       ocnt;

  cali_err_align #(
    .X_W(X_W), .TDC_W(TDC_W), .ERR_W(ERR_W), .DMAX(DMAX), .OTHR(OTHR)
  ) dut (
    .clk_i         (clk),
    .nrst_i        (nrst),
    .en_i          (en),
    .dly_i         (dly),
    .gshift_i      (gshift),
    .x_in_i        (x_in),
    .tdc_in_i      (tdc_in),
    .tdc_vld_i     (tdc_vld),
    .x_out_o       (x_out),
    .err_out_o     (err_out),
    .en_out_o      (en_out),
    .outlier_cnt_o (ocnt)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: edge index n, code history, and the first edge at which
  // the block is updating (ready_at) after an enable or a latency change.
  int n          = 0;
  int first_edge = 1;
  int hist[64];
  bit idle_m     = 1'b1;
  int ready_at   = 0;
  int dly_prev_m = 0;
  int ocnt_m     = 0;

  task automatic model_reset();
    idle_m     = 1'b1;
    ocnt_m     = 0;
    dly_prev_m = 0;
    first_edge = n + 1;
  endtask

  task automatic tick();
    int  dl, xe, ee, t, mag, prod;
    bit  run, outl, acc;
    @(posedge clk);
    n++;
    hist[n % 64] = int'(x_in);
    dl = (dly == 4'd0) ? 1 : int'(dly);
    if (dl > DMAX) dl = DMAX;
    xe   = (n - dl < first_edge) ? 0 : hist[(n - dl) % 64];
    t    = int'($signed(tdc_in));
    mag  = (t < 0) ? -t : t;
    outl = tdc_vld && (mag > OTHR);
    run  = !idle_m && en && (n >= ready_at);
    acc  = run && tdc_vld && !outl;
    prod = t * (1 << gshift);
    if (prod > 32767)  prod = 32767;
    if (prod < -32768) prod = -32768;
    ee = acc ? prod : 0;
    if (run && outl && ocnt_m < 255) ocnt_m++;
    if (!en) begin
      idle_m = 1'b1;
    end else if (idle_m) begin
      idle_m   = 1'b0;
      ready_at = n + dl + 1;
      ocnt_m   = 0;
    end else if (n >= ready_at && int'(dly) != dly_prev_m) begin
      ready_at = n + dl + 1;
    end
    dly_prev_m = int'(dly);
    #1;
    check_eq("x_out",       longint'(x_out), longint'(xe));
    check_eq("err_out",     longint'($signed(err_out)), longint'(ee));
    check_eq("en_out",      longint'(en_out), longint'(acc));
    check_eq("outlier_cnt", longint'(ocnt), longint'(ocnt_m));
  endtask

  task automatic run_ramp(input int k);
    for (int i = 0; i < k; i++) begin
      x_in = x_in + 1'b1;
      tick();
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check_eq({tag, "_x"},    longint'(x_out), 0);
    check_eq({tag, "_err"},  longint'(err_out), 0);
    check_eq({tag, "_en"},   longint'(en_out), 0);
    check_eq({tag, "_ocnt"}, longint'(ocnt), 0);
  endtask

  // Called just after a posedge: assert reset mid-cycle, check outputs before any edge.
  task automatic async_reset(input string tag);
    #3;
    nrst = 1'b0;
    #1;
    check_zero_outputs(tag);
    @(posedge clk);
    #2;
    nrst = 1'b1;
    model_reset();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int v;
    nrst = 1'b0; en = 1'b0; dly = 4'd0; gshift = 3'd0;
    x_in = '0; tdc_in = '0; tdc_vld = 1'b0;
    #12;
    check_zero_outputs("reset");
    nrst = 1'b1;
    model_reset();

    // Startup alignment at latency 3
    en = 1'b1; dly = 4'd3; tdc_vld = 1'b1; tdc_in = 10'd5;
    run_ramp(12);

    // Gain saturation both ways
    gshift = 3'd7; tdc_in = 10'd300;
    run_ramp(1);
    check_eq("sat_pos", longint'($signed(err_out)), 32767);
    tdc_in = 10'(-300);
    run_ramp(1);
    check_eq("sat_neg", longint'($signed(err_out)), -32768);

    // Outlier rejection then recovery
    gshift = 3'd0; tdc_in = 10'd400;
    run_ramp(3);
    check_eq("ocnt_three", longint'(ocnt), 3);
    tdc_in = 10'd10;
    run_ramp(1);
    check_eq("err_after_outlier", longint'($signed(err_out)), 10);

    // Latency change 3 -> 6, then DLY=0
    dly = 4'd6;
    run_ramp(10);
    dly = 4'd0;
    run_ramp(6);

    // Most negative code is always an outlier; counter saturates
    tdc_in = 10'h200;
    run_ramp(260);
    check_eq("ocnt_sat", longint'(ocnt), 255);
    tdc_in = 10'd7;

    // Enable drop, then reset in the middle of FILL
    dly = 4'd3;
    run_ramp(6);
    en = 1'b0;
    run_ramp(1);
    en = 1'b1;
    run_ramp(2);
    async_reset("rst_fill");
    run_ramp(10);

    for (int i = 0; i < 1500; i++) begin
      if (i == 700) async_reset("rst_rand");
      x_in    = X_W'($urandom_range(0, (1 << X_W) - 1));
      en      = ($urandom_range(0, 99) < 96);
      if ($urandom_range(0, 99) < 3) dly = 4'($urandom_range(0, 15));
      gshift  = 3'($urandom_range(0, 7));
      tdc_vld = ($urandom_range(0, 9) != 0);
      case ($urandom_range(0, 9))
        0:       v = -512;
        1:       v = int'($urandom_range(0, 1023)) - 512;
        2:       v = ($urandom_range(0, 1) != 0 ? 1 : -1) * int'($urandom_range(380, 390));
        default: v = int'($urandom_range(0, 100)) - 50;
      endcase
      tdc_in = 10'(v);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
